// File: rtl/vx_tensor_dispatch_arb_pkg.sv
// vx_tensor_dispatch_arb shared types.
// Arbiter lock state used by the top-level FSM.
package vx_tensor_dispatch_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vx_tensor_dispatch_arb_if.sv
// vx_tensor_dispatch_arb handshake bundle.
// Dispatch fan-in and commit fan-out between slots and datapath.
interface vx_tensor_dispatch_arb_if #(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 64,
    parameter int CMT_DATAW = 64
);
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      out_valid;
    logic [DATAW-1:0]          out_data;
    logic                      out_ready;
    logic                      cmt_in_valid;
    logic [CMT_DATAW-1:0]      cmt_in_data;
    logic                      cmt_in_ready;
    logic [NUM_REQS-1:0]       cmt_out_valid;
    logic [CMT_DATAW-1:0]      cmt_out_data;
    logic [NUM_REQS-1:0]       cmt_out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        output cmt_in_valid, cmt_in_data, cmt_out_ready,
        input  req_ready, out_valid, out_data,
        input  cmt_in_ready, cmt_out_valid, cmt_out_data
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        input  cmt_in_valid, cmt_in_data, cmt_out_ready,
        output req_ready, out_valid, out_data,
        output cmt_in_ready, cmt_out_valid, cmt_out_data
    );
endinterface

// File: rtl/vx_tensor_dispatch_arb_fifo.sv
// In-order ID queue for vx_tensor_dispatch_arb.
// Head is read combinationally; size feeds the reservation check.
module VX_fifo_queue #(
    parameter int DATAW = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATAW-1:0]       data_in,
    output logic [DATAW-1:0]       data_out,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] size
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (size == '0);
    assign do_push  = push && (size != (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // storage write, no reset needed on payload
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

    // wrapping pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            size   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                size <= size + (AW+1)'(1);
            else if (!do_push && do_pop)
                size <= size - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/vx_tensor_dispatch_arb.sv
// Tensor-core dispatch arbiter with group lock and commit routing.
// Requester IDs are queued per group so commits return in order.
module vx_tensor_dispatch_arb
    import vx_tensor_dispatch_arb_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int DATAW     = 64,
    parameter int CMT_DATAW = 64,
    parameter int GRP_BEATS = 2,
    parameter int CMT_BEATS = 2,
    parameter int ID_DEPTH  = 8
) (
    input logic                    clk,
    input logic                    reset,
    vx_tensor_dispatch_arb_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQS);
    localparam int BW  = $clog2(GRP_BEATS+1);
    localparam int CBW = $clog2(CMT_BEATS+1);
    localparam int SW  = $clog2(ID_DEPTH)+1;

    arb_state_e     state, state_n;
    logic [IDW-1:0] owner, owner_n;
    logic [IDW-1:0] rr_ptr, rr_ptr_n;
    logic [IDW-1:0] cand, sel, head;
    logic [BW-1:0]  beat, beat_n, beat_inc;
    logic [CBW-1:0] cbeat, cbeat_n;
    logic           found, fwd_valid, fire, grp_done;
    logic           push, pop, fifo_empty, cmt_fire;
    logic [SW-1:0]  fifo_size;

    function automatic logic [IDW-1:0] next_idx(
        input logic [IDW-1:0] i
    );
        return (int'(i) == NUM_REQS-1) ? '0 : i + IDW'(1);
    endfunction

    // rotating priority search starting at rr_ptr
    always_comb begin
        int idx;
        idx   = 0;
        cand  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQS;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                cand  = IDW'(idx);
            end
        end
    end

    // lock FSM: grant selection, beat counting, group push
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        beat_n    = beat;
        rr_ptr_n  = rr_ptr;
        push      = 1'b0;
        sel       = owner;
        fwd_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                sel       = cand;
                fwd_valid = found && (fifo_size < SW'(ID_DEPTH));
            end
            ST_LOCKED: begin
                sel       = owner;
                fwd_valid = bus.req_valid[owner];
            end
            default: ;
        endcase
        fire     = fwd_valid && bus.out_ready;
        beat_inc = ((state == ST_LOCKED) ? beat : '0) + BW'(1);
        grp_done = fire && (beat_inc == BW'(GRP_BEATS));
        if (grp_done) begin
            push     = 1'b1;
            rr_ptr_n = next_idx(sel);
            beat_n   = '0;
            state_n  = ST_IDLE;
        end else if (fire) begin
            state_n = ST_LOCKED;
            owner_n = sel;
            beat_n  = beat_inc;
        end
    end

    assign bus.out_valid = fwd_valid;
    assign bus.out_data  = bus.req_data[int'(sel)*DATAW +: DATAW];
    assign bus.req_ready = fire ? (NUM_REQS'(1) << sel) : '0;

    assign bus.cmt_in_ready  = !fifo_empty && bus.cmt_out_ready[head];
    assign bus.cmt_out_valid = (bus.cmt_in_valid && !fifo_empty)
                             ? (NUM_REQS'(1) << head) : '0;
    assign bus.cmt_out_data  = bus.cmt_in_data;
    assign cmt_fire          = bus.cmt_in_valid && bus.cmt_in_ready;

    // commit beat counter, pop on the last beat of a group
    always_comb begin
        cbeat_n = cbeat;
        pop     = 1'b0;
        if (cmt_fire) begin
            if (cbeat + CBW'(1) == CBW'(CMT_BEATS)) begin
                pop     = 1'b1;
                cbeat_n = '0;
            end else begin
                cbeat_n = cbeat + CBW'(1);
            end
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            owner  <= '0;
            beat   <= '0;
            rr_ptr <= '0;
            cbeat  <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            beat   <= beat_n;
            rr_ptr <= rr_ptr_n;
            cbeat  <= cbeat_n;
        end
    end

    VX_fifo_queue #(
        .DATAW (IDW),
        .DEPTH (ID_DEPTH)
    ) id_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (sel),
        .data_out (head),
        .empty    (fifo_empty),
        .size     (fifo_size)
    );

    a_no_orphan_commit: assert property (
        @(posedge clk) disable iff (reset)
        !(bus.cmt_in_valid && fifo_empty)
    );
endmodule

// File: tb/tb_vx_tensor_dispatch_arb.sv
// Bench for vx_tensor_dispatch_arb.
// Queue-based reference model plus directed scenarios.
module tb_vx_tensor_dispatch_arb;
    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int CW    = 64;
    localparam int GB    = 2;
    localparam int CB    = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_tensor_dispatch_arb_if #(
        .NUM_REQS(N), .DATAW(DW), .CMT_DATAW(CW)
    ) bus ();

    vx_tensor_dispatch_arb #(
        .NUM_REQS(N), .DATAW(DW), .CMT_DATAW(CW),
        .GRP_BEATS(GB), .CMT_BEATS(CB), .ID_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] req_pay [N];
    int n_cmp  = 0;
    int n_fail = 0;

    int m_queue[$];
    bit m_locked = 0;
    int m_owner  = 0;
    int m_beats  = 0;
    int m_rr     = 0;
    int m_cbeats = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // what the outputs must be, from model state and current inputs
    task automatic model_eval(output bit v, output int s,
                              output logic [3:0] rr,
                              output bit cir,
                              output logic [3:0] cov);
        v = 0;
        s = 0;
        if (m_locked) begin
            s = m_owner;
            v = bus.req_valid[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (bus.req_valid[j]) begin
                    s = j;
                    v = (m_queue.size() < DEPTH);
                    break;
                end
            end
        end
        rr  = (v && bus.out_ready) ? 4'(1 << s) : 4'b0;
        cir = (m_queue.size() > 0) && bus.cmt_out_ready[m_queue[0]];
        cov = (bus.cmt_in_valid && m_queue.size() > 0)
            ? 4'(1 << m_queue[0]) : 4'b0;
    endtask

    always @(posedge clk) begin
        bit v, cir;
        int s;
        logic [3:0] rr, cov;
        if (reset) begin
            m_queue.delete();
            m_locked = 0;
            m_beats  = 0;
            m_rr     = 0;
            m_cbeats = 0;
        end else begin
            model_eval(v, s, rr, cir, cov);
            if (bus.cmt_in_valid && cir) begin
                m_cbeats++;
                if (m_cbeats == CB) begin
                    m_cbeats = 0;
                    void'(m_queue.pop_front());
                end
            end
            if (v && bus.out_ready) begin
                if (!m_locked) begin
                    m_locked = 1;
                    m_owner  = s;
                end
                m_beats++;
                if (m_beats == GB) begin
                    m_queue.push_back(m_owner);
                    m_rr     = (m_owner + 1) % N;
                    m_locked = 0;
                    m_beats  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit v, cir;
        int s;
        logic [3:0] rr, cov;
        if (!reset) begin
            model_eval(v, s, rr, cir, cov);
            chk("m_out_valid", bus.out_valid, v);
            if (v)
                chk("m_out_data", bus.out_data, req_pay[s]);
            chk("m_req_ready", bus.req_ready, rr);
            chk("m_cmt_in_ready", bus.cmt_in_ready, cir);
            chk("m_cmt_out_valid", bus.cmt_out_valid, cov);
            if (bus.cmt_in_valid)
                chk("m_cmt_out_data", bus.cmt_out_data,
                    bus.cmt_in_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic group(input int r);
        bus.req_valid = 4'(1 << r);
        cyc();
        cyc();
        bus.req_valid = '0;
    endtask

    task automatic drain(input int beats);
        bus.cmt_in_valid = 1'b1;
        repeat (beats) cyc();
        bus.cmt_in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++)
            req_pay[i] = 64'hD0D0_0000_0000_0000 | 64'(i);
        reset             = 1'b1;
        bus.req_valid     = '0;
        for (int i = 0; i < N; i++)
            bus.req_data[i*DW +: DW] = req_pay[i];
        bus.out_ready     = 1'b0;
        bus.cmt_in_valid  = 1'b0;
        bus.cmt_in_data   = 64'hC0FFEE;
        bus.cmt_out_ready = 4'hF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_cmt_in_ready", bus.cmt_in_ready, 0);
        chk("rst_cmt_out_valid", bus.cmt_out_valid, 0);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("idle_out_valid", bus.out_valid, 1);
        chk("idle_req_ready", bus.req_ready, 0);
        chk("idle_out_data", bus.out_data, req_pay[2]);
        cyc();
        bus.req_valid = '0;
        bus.out_ready = 1'b1;

        // lock holds against competition
        bus.req_valid = 4'b0011;
        @(negedge clk); chk("s1_b0", bus.req_ready, 4'b0001);
        cyc();
        @(negedge clk); chk("s1_b1", bus.req_ready, 4'b0001);
        cyc();
        @(negedge clk); chk("s1_b2", bus.req_ready, 4'b0010);
        chk("s1_data", bus.out_data, req_pay[1]);
        cyc();
        @(negedge clk); chk("s1_b3", bus.req_ready, 4'b0010);
        cyc();
        bus.req_valid = '0;
        bus.cmt_in_valid = 1'b1;
        @(negedge clk); chk("s1_c0", bus.cmt_out_valid, 4'b0001);
        cyc();
        @(negedge clk); chk("s1_c1", bus.cmt_out_valid, 4'b0001);
        cyc();
        @(negedge clk); chk("s1_c2", bus.cmt_out_valid, 4'b0010);
        cyc();
        cyc();
        bus.cmt_in_valid = 1'b0;

        // owner stalls mid-group
        bus.req_valid = 4'b1100;
        @(negedge clk); chk("s2_grant", bus.req_ready, 4'b0100);
        cyc();
        bus.req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s2_stall_ov", bus.out_valid, 0);
            chk("s2_stall_rr", bus.req_ready, 0);
            cyc();
        end
        bus.req_valid = 4'b1100;
        @(negedge clk); chk("s2_resume", bus.req_ready, 4'b0100);
        cyc();
        @(negedge clk); chk("s2_next", bus.req_ready, 4'b1000);
        cyc();
        cyc();
        bus.req_valid = '0;
        drain(4);

        // commit routing with backpressure
        group(1);
        group(3);
        bus.cmt_out_ready = 4'b1101;
        bus.cmt_in_valid  = 1'b1;
        @(negedge clk);
        chk("s3_hold_cir", bus.cmt_in_ready, 0);
        chk("s3_hold_cov", bus.cmt_out_valid, 4'b0010);
        cyc();
        bus.cmt_out_ready = 4'hF;
        @(negedge clk); chk("s3_c0", bus.cmt_out_valid, 4'b0010);
        cyc();
        @(negedge clk); chk("s3_c1", bus.cmt_out_valid, 4'b0010);
        cyc();
        @(negedge clk); chk("s3_c2", bus.cmt_out_valid, 4'b1000);
        cyc();
        @(negedge clk); chk("s3_c3", bus.cmt_out_valid, 4'b1000);
        cyc();
        bus.cmt_in_valid = 1'b0;

        // full ID FIFO blocks the ninth group
        bus.req_valid = 4'b0001;
        repeat (16) cyc();
        @(negedge clk);
        chk("s4_full_ov", bus.out_valid, 0);
        chk("s4_full_rr", bus.req_ready, 0);
        bus.cmt_in_valid = 1'b1;
        cyc();
        @(negedge clk); chk("s4_pop_ov", bus.out_valid, 0);
        cyc();
        bus.cmt_in_valid = 1'b0;
        @(negedge clk); chk("s4_resume", bus.out_valid, 1);
        cyc();
        cyc();
        bus.req_valid = '0;
        drain(16);

        // push and pop in the same cycle
        group(0);
        bus.req_valid    = 4'b0100;
        bus.cmt_in_valid = 1'b1;
        cyc();
        cyc();
        bus.req_valid = '0;
        @(negedge clk); chk("s5_head", bus.cmt_out_valid, 4'b0100);
        cyc();
        cyc();
        bus.cmt_in_valid = 1'b0;

        // reset mid-group with IDs queued
        group(1);
        group(2);
        group(3);
        bus.req_valid = 4'b0001;
        cyc();
        reset = 1'b1;
        bus.req_valid = 4'b0110;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("s6_cir", bus.cmt_in_ready, 0);
        chk("s6_rr", bus.req_ready, 4'b0010);
        chk("s6_ov", bus.out_valid, 1);
        cyc();
        cyc();
        bus.req_valid = '0;
        drain(2);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
